fu_alu_pipe: RTL and testbench
==============================

# fu_alu_pipe

Pipelined, parametrised integer ALU functional unit for the out-of-order core's execute stage. It replaces the fixed one-cycle, 32-bit, single-in-flight ALU unit. It accepts one tagged operation per cycle through a valid/ready issue port, returns the tagged result after a configurable number of stages through a valid/ready result port, and supports a flush that kills all in-flight work.

## Interface
- XLEN, 32, operand/result width (8..64, power of two)
- STAGES, 2, pipeline depth = issue-to-result latency in cycles (1..4)
- TAG_W, 4, width of the reservation-station tag carried with each op
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all in-flight ops
- issue_valid  in  1  issue request
- issue_ready  out  1  unit can accept this cycle
- issue_op  in  4  operation code (encoding below)
- issue_a, issue_b  in  XLEN  operands
- issue_tag  in  TAG_W  destination tag
- res_valid  out  1  result available
- res_ready  in  1  consumer (CDB arbiter) accepts result
- res  out  XLEN  result
- res_tag  out  TAG_W  tag of result
- zero  out  1  res == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- busy  out  1  any stage holds a valid op

## Operation
- Op codes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SLT, 9 SLTU, 10 SRA, 11 A+4, 12 pass B. Codes 0, 13, 14 and 15 give res=0 and overflow=0.
- Shift amount = issue_b[log2(XLEN)-1:0]. SRA sign-fills from a[XLEN-1].
- SLT: signed compare, (a-b) sign XOR sub-overflow. SLTU: borrow of zero-extended (XLEN+1)-bit subtraction. Result is 0 or 1, zero-extended.
- ADD overflow: operand signs equal and result sign differs. SUB overflow: operand signs differ and result sign differs from a. All arithmetic wraps modulo 2^XLEN.
- The result, zero and overflow are computed combinationally from issue inputs and captured into stage 0. Stages 1..STAGES-1 are pure delay registers (valid, res, tag, zero, overflow). The last stage drives the outputs.
- Bubble-collapsing flow control: ready[STAGES]=res_ready; ready[i] = !v[i] || ready[i+1]; issue_ready = ready[0]. Stage i loads from i-1 (or from issue for i=0) when ready[i]. Its valid bit loads the upstream valid.
- Output transfer occurs on a clock edge when res_valid && res_ready.
- While res_valid && !res_ready, res, res_tag, zero and overflow stay constant.
- busy = OR of all stage valid bits.

## Timing
- Reset (async assert, release on clk edge): all valid bits 0, all data registers 0. Outputs: res_valid=0, res=0, res_tag=0, zero=1, overflow=0, busy=0. issue_ready=1 once out of reset.
- Latency: an op accepted at edge E appears with res_valid=1 in the cycle following edge E+STAGES-1. For STAGES=1, this is the cycle right after acceptance.
- Throughput: 1 op/cycle with res_ready held high. No bubbles are inserted.
- Backpressure: with res_ready=0, at most STAGES ops are held. issue_ready falls only when all stages are valid.
- Bubbles: an empty intermediate stage is filled even when the output is stalled.
- flush=1 at an edge clears every valid bit. An issue handshake in the same cycle is discarded. Data registers need not clear. The next cycle has res_valid=0, busy=0, issue_ready=1.
- flush and output handshake in the same cycle: the output transfer counts as completed.
- Reset asserted mid-operation: all state clears immediately, independent of clk.
- issue_ready depends combinationally on res_ready. This path is documented and permitted. There is no combinational path from issue_* to res_*.

## Test plan
- STAGES=2, XLEN=32, res_ready=1: issue ADD 0x7FFFFFFF+1, tag 3 → two cycles later res_valid=1, res=0x80000000, res_tag=3, overflow=1, zero=0.
- Back-to-back issue of SUB 5-5, SLT 0xFFFFFFFF vs 1, SLTU 0xFFFFFFFF vs 1, SRA 0x80000000 by 4 → results 0 (zero=1), 1, 0, 0xF8000000 on four consecutive cycles.
- res_ready=0, issue 3 ops with STAGES=2 → issue_ready drops after the second acceptance. res holds the first result stable. Raise res_ready → results drain in order, one per cycle.
- Stall with a bubble: issue one op, idle one cycle, issue a second op, res_ready=0 → both stages become valid and issue_ready=0.
- flush with 2 valid ops and a simultaneous issue → the next cycle has busy=0 and res_valid=0, and no result ever appears for the three tags.
- XLEN=16, STAGES=1: SLL 0x0001 by 0x0013 (shamt=3) → 0x0008 one cycle later. Op code 14 → res=0, zero=1. Assert rst_n=0 mid-stream → res_valid drops without a clock edge.

Source files
------------

// File: rtl/fu_alu_pipe_if.sv
// Issue and result handshake bundle for the pipelined ALU unit.
// The unit is the slave; the reservation station / CDB side is the master.
interface fu_alu_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_op;
  logic [XLEN-1:0]  issue_a;
  logic [XLEN-1:0]  issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res;
  logic [TAG_W-1:0] res_tag;
  logic             zero;
  logic             overflow;

  modport master (
    output issue_valid, issue_op, issue_a,
    output issue_b, issue_tag, res_ready,
    input  issue_ready, res_valid, res,
    input  res_tag, zero, overflow
  );

  modport slave (
    input  issue_valid, issue_op, issue_a,
    input  issue_b, issue_tag, res_ready,
    output issue_ready, res_valid, res,
    output res_tag, zero, overflow
  );
endinterface

// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU: compute at issue, then a bubble-collapsing
// delay line of STAGES tagged result registers.
module fu_alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          busy,
  fu_alu_pipe_if.slave  bus
);
  localparam int SH_W = $clog2(XLEN);
  localparam int M    = XLEN - 1;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             ovf;
  } stage_t;

  localparam stage_t ST_RST = '{
    res:  '0,
    tag:  '0,
    zero: 1'b1,
    ovf:  1'b0
  };

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN:0]   diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic            slt;
  logic            sltu;
  logic [XLEN-1:0] alu_res;
  logic            alu_ovf;
  stage_t          iss;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES:0]   rdy;

  assign a     = bus.issue_a;
  assign b     = bus.issue_b;
  assign shamt = b[SH_W-1:0];
  assign sum   = a + b;
  assign diff  = {1'b0, a} - {1'b0, b};

  assign add_ovf = (a[M] == b[M]) &&
                   (sum[M] != a[M]);
  assign sub_ovf = (a[M] != b[M]) &&
                   (diff[M] != a[M]);
  assign slt     = diff[M] ^ sub_ovf;
  assign sltu    = diff[XLEN];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (1'b1)
      (bus.issue_op == 4'd1): begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      (bus.issue_op == 4'd2): begin
        alu_res = diff[M:0];
        alu_ovf = sub_ovf;
      end
      (bus.issue_op == 4'd3):
        alu_res = a & b;
      (bus.issue_op == 4'd4):
        alu_res = a | b;
      (bus.issue_op == 4'd5):
        alu_res = a ^ b;
      (bus.issue_op == 4'd6):
        alu_res = a << shamt;
      (bus.issue_op == 4'd7):
        alu_res = a >> shamt;
      (bus.issue_op == 4'd8):
        alu_res = XLEN'(slt);
      (bus.issue_op == 4'd9):
        alu_res = XLEN'(sltu);
      (bus.issue_op == 4'd10):
        alu_res = $unsigned($signed(a) >>> shamt);
      (bus.issue_op == 4'd11):
        alu_res = a + XLEN'(4);
      (bus.issue_op == 4'd12):
        alu_res = b;
      default: ;
    endcase
  end

  always_comb begin
    iss.res  = alu_res;
    iss.tag  = bus.issue_tag;
    iss.zero = (alu_res == '0);
    iss.ovf  = alu_ovf;
  end

  // A stage can load whenever it is empty or its successor moves.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = bus.res_ready;
    for (int i = STAGES - 1; i >= 0; i--)
      rdy[i] = !v_q[i] || rdy[i+1];
    v_d  = v_q;
    st_d = st_q;
    if (rdy[0]) begin
      v_d[0]  = bus.issue_valid;
      st_d[0] = iss;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i]  = v_q[i-1];
        st_d[i] = st_q[i-1];
      end
    end
    if (flush)
      v_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++)
        st_q[i] <= ST_RST;
    end else begin
      v_q  <= v_d;
      st_q <= st_d;
    end
  end

  assign bus.issue_ready = rdy[0];
  assign bus.res_valid   = v_q[STAGES-1];
  assign bus.res         = st_q[STAGES-1].res;
  assign bus.res_tag     = st_q[STAGES-1].tag;
  assign bus.zero        = st_q[STAGES-1].zero;
  assign bus.overflow    = st_q[STAGES-1].ovf;
  assign busy            = |v_q;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed bench for fu_alu_pipe: a 32-bit two-stage unit and a
// 16-bit single-stage unit, each driven on the falling edge.
module tb_fu_alu_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic flush = 1'b0;
  logic flush2 = 1'b0;
  logic busy;
  logic busy2;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fu_alu_pipe_if #(.XLEN(32), .TAG_W(4)) b1 ();
  fu_alu_pipe_if #(.XLEN(16), .TAG_W(4)) b2 ();

  fu_alu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (b1.slave)
  );

  fu_alu_pipe #(.XLEN(16), .STAGES(1), .TAG_W(4)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .flush (flush2),
    .busy  (busy2),
    .bus   (b2.slave)
  );

  task automatic drv1(input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    b1.issue_valid = v;
    b1.issue_op    = op;
    b1.issue_a     = a;
    b1.issue_b     = b;
    b1.issue_tag   = tag;
  endtask

  task automatic drv2(input logic v, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag);
    b2.issue_valid = v;
    b2.issue_op    = op;
    b2.issue_a     = a;
    b2.issue_b     = b;
    b2.issue_tag   = tag;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({b1.res_valid, b1.res, b1.res_tag, b1.zero,
         b1.overflow, busy} !== {1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset1 got v=%b r=%h t=%h z=%b o=%b busy=%b exp 0 0 0 1 0 0",
               b1.res_valid, b1.res, b1.res_tag, b1.zero, b1.overflow, busy);
    end
    checks++;
    if ({b2.res_valid, b2.res, b2.zero, busy2} !== {1'b0, 16'h0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset2 got v=%b r=%h z=%b busy=%b exp 0 0 1 0",
               b2.res_valid, b2.res, b2.zero, busy2);
    end
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b exp 1", b1.issue_ready);
    end
  endtask

  task automatic test_add_ovf();
    drv1(1'b1, 4'd1, 32'h7FFF_FFFF, 32'h1, 4'd3);
    @(negedge clk);
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    checks++;
    if (b1.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL add_early got valid=%b exp 0", b1.res_valid);
    end
    @(negedge clk);
    checks++;
    if ({b1.res_valid, b1.res, b1.res_tag, b1.overflow, b1.zero}
        !== {1'b1, 32'h8000_0000, 4'd3, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL add_ovf got v=%b r=%h t=%h o=%b z=%b exp 1 80000000 3 1 0",
               b1.res_valid, b1.res, b1.res_tag, b1.overflow, b1.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    ops = '{4'd2, 4'd8, 4'd9, 4'd10};
    as  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'd5, 32'd1, 32'd1, 32'd4};
    exp = '{32'h0, 32'h1, 32'h0, 32'hF800_0000};
    for (int n = 0; n < 6; n++) begin
      if (n >= 2) begin
        checks++;
        if ({b1.res_valid, b1.res, b1.res_tag, b1.zero}
            !== {1'b1, exp[n-2], 4'(n + 8), (exp[n-2] == 32'h0)}) begin
          errs++;
          $display("FAIL b2b[%0d] got v=%b r=%h t=%h z=%b exp r=%h t=%h",
                   n - 2, b1.res_valid, b1.res, b1.res_tag, b1.zero,
                   exp[n-2], 4'(n + 8));
        end
      end
      if (n < 4)
        drv1(1'b1, ops[n], as[n], bs[n], 4'(n + 10));
      else
        drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    b1.res_ready = 1'b0;
    drv1(1'b1, 4'd1, 32'd1, 32'd2, 4'd1);
    @(negedge clk);
    checks++;
    if (b1.issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_ready1 got %b exp 1", b1.issue_ready);
    end
    drv1(1'b1, 4'd4, 32'hF0, 32'h0F, 4'd2);
    @(negedge clk);
    checks++;
    if ({b1.issue_ready, b1.res_valid, b1.res, b1.res_tag}
        !== {1'b0, 1'b1, 32'd3, 4'd1}) begin
      errs++;
      $display("FAIL bp_full got rdy=%b v=%b r=%h t=%h exp 0 1 3 1",
               b1.issue_ready, b1.res_valid, b1.res, b1.res_tag);
    end
    drv1(1'b1, 4'd5, 32'hFF, 32'h0F, 4'd3);
    @(negedge clk);
    checks++;
    if ({b1.issue_ready, b1.res, b1.res_tag} !== {1'b0, 32'd3, 4'd1}) begin
      errs++;
      $display("FAIL bp_hold got rdy=%b r=%h t=%h exp 0 3 1",
               b1.issue_ready, b1.res, b1.res_tag);
    end
    b1.res_ready = 1'b1;
    @(negedge clk);
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    checks++;
    if ({b1.res_valid, b1.res, b1.res_tag} !== {1'b1, 32'hFF, 4'd2}) begin
      errs++;
      $display("FAIL bp_drain2 got v=%b r=%h t=%h exp 1 ff 2",
               b1.res_valid, b1.res, b1.res_tag);
    end
    @(negedge clk);
    checks++;
    if ({b1.res_valid, b1.res, b1.res_tag} !== {1'b1, 32'hF0, 4'd3}) begin
      errs++;
      $display("FAIL bp_drain3 got v=%b r=%h t=%h exp 1 f0 3",
               b1.res_valid, b1.res, b1.res_tag);
    end
    @(negedge clk);
    checks++;
    if (b1.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_empty got v=%b exp 0", b1.res_valid);
    end
  endtask

  task automatic test_bubble();
    b1.res_ready = 1'b0;
    drv1(1'b1, 4'd3, 32'hFF, 32'h3C, 4'd5);
    @(negedge clk);
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    drv1(1'b1, 4'd11, 32'h10, 32'h0, 4'd6);
    @(negedge clk);
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    checks++;
    if ({b1.issue_ready, busy, b1.res_valid, b1.res, b1.res_tag}
        !== {1'b0, 1'b1, 1'b1, 32'h3C, 4'd5}) begin
      errs++;
      $display("FAIL bubble got rdy=%b busy=%b v=%b r=%h t=%h exp 0 1 1 3c 5",
               b1.issue_ready, busy, b1.res_valid, b1.res, b1.res_tag);
    end
    b1.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({b1.res_valid, b1.res, b1.res_tag} !== {1'b1, 32'h14, 4'd6}) begin
      errs++;
      $display("FAIL bubble_drain got v=%b r=%h t=%h exp 1 14 6",
               b1.res_valid, b1.res, b1.res_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    b1.res_ready = 1'b0;
    drv1(1'b1, 4'd12, 32'h0, 32'h77, 4'd7);
    @(negedge clk);
    drv1(1'b1, 4'd12, 32'h0, 32'h88, 4'd8);
    @(negedge clk);
    drv1(1'b1, 4'd12, 32'h0, 32'h99, 4'd9);
    b1.res_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    checks++;
    if ({busy, b1.res_valid, b1.issue_ready} !== 3'b001) begin
      errs++;
      $display("FAIL flush got busy=%b v=%b rdy=%b exp 0 0 1",
               busy, b1.res_valid, b1.issue_ready);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (b1.res_valid !== 1'b0) begin
        errs++;
        $display("FAIL flush_ghost[%0d] got v=%b t=%h exp 0",
                 n, b1.res_valid, b1.res_tag);
      end
    end
  endtask

  task automatic test_narrow();
    b2.res_ready = 1'b1;
    drv2(1'b1, 4'd6, 16'h0001, 16'h0013, 4'd2);
    @(negedge clk);
    checks++;
    if ({b2.res_valid, b2.res, b2.res_tag} !== {1'b1, 16'h0008, 4'd2}) begin
      errs++;
      $display("FAIL sll16 got v=%b r=%h t=%h exp 1 0008 2",
               b2.res_valid, b2.res, b2.res_tag);
    end
    drv2(1'b1, 4'd14, 16'h1234, 16'h0005, 4'd9);
    @(negedge clk);
    checks++;
    if ({b2.res_valid, b2.res, b2.zero, b2.res_tag}
        !== {1'b1, 16'h0, 1'b1, 4'd9}) begin
      errs++;
      $display("FAIL op14 got v=%b r=%h z=%b t=%h exp 1 0 1 9",
               b2.res_valid, b2.res, b2.zero, b2.res_tag);
    end
    drv2(1'b1, 4'd2, 16'h8000, 16'h0001, 4'd4);
    @(negedge clk);
    checks++;
    if ({b2.res_valid, b2.res, b2.overflow} !== {1'b1, 16'h7FFF, 1'b1}) begin
      errs++;
      $display("FAIL sub16_ovf got v=%b r=%h o=%b exp 1 7fff 1",
               b2.res_valid, b2.res, b2.overflow);
    end
    b2.res_ready = 1'b0;
    drv2(1'b1, 4'd1, 16'h0001, 16'h0001, 4'd5);
    @(negedge clk);
    drv2(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
    rst2_n = 1'b0;
    #1;
    checks++;
    if ({b2.res_valid, busy2} !== 2'b00) begin
      errs++;
      $display("FAIL async_rst got v=%b busy=%b exp 0 0",
               b2.res_valid, busy2);
    end
    @(negedge clk);
    rst2_n = 1'b1;
  endtask

  initial begin
    drv1(1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
    drv2(1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
    b1.res_ready = 1'b1;
    b2.res_ready = 1'b1;
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_flush();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
